// File: rtl/weight_dispatcher.sv
// rtl/weight_dispatcher.sv - weight buffer read sequencer with credit-limited skid FIFO.
// Optional stall counters are enabled by defining WDISP_PERF_CNT_EN.
module weight_dispatcher #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 4096,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W:0]   cfg_num_rows,
  input  logic [7:0]        cfg_num_pass,
  input  logic              cfg_abort,
  output logic              busy,
  output logic              done,
  input  logic              wb_dram_wr,
  output logic              out_disp_req,
  output logic [ADDR_W-1:0] out_disp_addr,
  input  logic [DATA_W-1:0] in_disp_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
`ifdef WDISP_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_bp,
  output logic [31:0]       perf_stall_wr
`endif
);

  localparam int RW    = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ptr_q, ptr_d;
  logic [RW-1:0]     rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic [7:0]        pass_q, pass_d, pass_cnt_q, pass_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   mem_d [FIFO_DEPTH];
  logic              done_q, done_d;
  logic              credit_ok, abort_acc, issue, last_row, last_pass, ret, push, pop;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rows_d     = rows_q;
    pass_d     = pass_q;
    ptr_d      = ptr_q;
    row_cnt_d  = row_cnt_q;
    pass_cnt_d = pass_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    done_d     = 1'b0;

    abort_acc  = cfg_abort && (state_q == S_RUN || state_q == S_DRAIN);
    credit_ok  = (inflight_q + fifo_cnt_q) < DEPTH_C;
    issue      = (state_q == S_RUN) && credit_ok && !wb_dram_wr && !abort_acc;
    last_row   = (row_cnt_q == rows_q - RW'(1));
    last_pass  = (pass_cnt_q == pass_q - 8'd1);

    // Each issue is tagged; the tag for the globally last row rides alongside.
    ret        = vld_q[RD_LAT-1];
    vld_d      = (vld_q << 1) | RD_LAT'(issue);
    lst_d      = (lst_q << 1) | RD_LAT'(issue && last_row && last_pass);
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);

    push = ret && (state_q != S_FLUSH) && !abort_acc;
    pop  = (fifo_cnt_q != '0) && m_ready;
    if (abort_acc) begin
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {lst_q[RD_LAT-1], in_disp_rdata};
        wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          base_d     = cfg_base_addr;
          rows_d     = cfg_num_rows;
          pass_d     = (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
          ptr_d      = cfg_base_addr;
          row_cnt_d  = '0;
          pass_cnt_d = '0;
          if (cfg_num_rows == '0) done_d = 1'b1;
          else                    state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_acc) begin
          state_d = S_FLUSH;
        end else if (issue) begin
          if (last_row) begin
            row_cnt_d = '0;
            ptr_d     = base_q;
            if (last_pass) state_d = S_DRAIN;
            else           pass_cnt_d = pass_cnt_q + 8'd1;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
            ptr_d     = ptr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort_acc) begin
          state_d = S_FLUSH;
        end else if (inflight_q == '0 && fifo_cnt_d == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (inflight_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      pass_q     <= '0;
      ptr_q      <= '0;
      row_cnt_q  <= '0;
      pass_cnt_q <= '0;
      vld_q      <= '0;
      lst_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      pass_q     <= pass_d;
      ptr_q      <= ptr_d;
      row_cnt_q  <= row_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign out_disp_req  = issue;
  assign out_disp_addr = ptr_q;
  assign m_valid       = (fifo_cnt_q != '0);
  assign m_data        = mem_q[rd_ptr_q][DATA_W-1:0];
  assign m_last        = mem_q[rd_ptr_q][DATA_W];

`ifdef WDISP_PERF_CNT_EN
  logic [31:0] stall_bp_q, stall_bp_d, stall_wr_q, stall_wr_d;

  always_comb begin
    stall_bp_d = stall_bp_q;
    stall_wr_d = stall_wr_q;
    if (state_q == S_IDLE && cfg_start) begin
      stall_bp_d = '0;
      stall_wr_d = '0;
    end else if (state_q == S_RUN) begin
      if (!credit_ok && stall_bp_q != '1) stall_bp_d = stall_bp_q + 32'd1;
      if (credit_ok && wb_dram_wr && stall_wr_q != '1) stall_wr_d = stall_wr_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_bp_q <= '0;
      stall_wr_q <= '0;
    end else begin
      stall_bp_q <= stall_bp_d;
      stall_wr_q <= stall_wr_d;
    end
  end

  assign perf_stall_bp = stall_bp_q;
  assign perf_stall_wr = stall_wr_q;
`endif

endmodule
